// File: rtl/bus_access_arbiter.sv
// Two-requester bus sequencer for the core bus: prefetch (PF) and data (DT).
// One transaction at a time, DT preferred, starvation counter guarantees PF progress.
module bus_access_arbiter #(
  parameter int DATA_STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pf_req,
  input  logic [31:0] pf_address,
  output logic        pf_grant,
  output logic        pf_done,
  output logic [31:0] pf_data,
  input  logic        dt_req,
  input  logic        dt_write_enable,
  input  logic [31:0] dt_address,
  input  logic [31:0] dt_write_data,
  output logic        dt_grant,
  output logic        dt_done,
  output logic [31:0] dt_data,
  output logic        bus_vaild,
  input  logic        bus_ready,
  output logic        bus_write_enable,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_data,
  output logic        bus_timeout,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds req and its fields until its grant pulse; the grant
  // cycle latches the fields. bus_vaild stays high until the cycle where bus_ready is
  // sampled high (or the timeout expires); the owner's done pulse follows one cycle later.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PF_BUS = 2'd1,
    DT_BUS = 2'd2
  } state_t;

  localparam int SW        = $clog2(DATA_STARVE_LIMIT + 1);
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 2);
  localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_t         state_q, state_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           pf_grant_q, pf_grant_d;
  logic           pf_done_q, pf_done_d;
  logic [31:0]    pf_data_q, pf_data_d;
  logic           dt_grant_q, dt_grant_d;
  logic           dt_done_q, dt_done_d;
  logic [31:0]    dt_data_q, dt_data_d;
  logic           vaild_q, vaild_d;
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wd_q, wd_d;
  logic           timeout_q, timeout_d;

  logic dt_win, pf_win, bus_ack, tmo_hit, finish;

  always_comb begin
    dt_win  = (state_q == IDLE) && dt_req &&
              (!pf_req || (starve_q < SW'(DATA_STARVE_LIMIT)));
    pf_win  = (state_q == IDLE) && !dt_win && pf_req;
    bus_ack = vaild_q && bus_ready;
    // bus_ready on the terminal-count cycle takes precedence over the abort
    tmo_hit = (TIMEOUT_CYCLES > 0) && vaild_q && !bus_ready && (tcnt_q == TW'(TO_LAST_I));
    finish  = bus_ack || tmo_hit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      tcnt_q     <= '0;
      pf_grant_q <= 1'b0;
      pf_done_q  <= 1'b0;
      pf_data_q  <= '0;
      dt_grant_q <= 1'b0;
      dt_done_q  <= 1'b0;
      dt_data_q  <= '0;
      vaild_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wd_q       <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      tcnt_q     <= tcnt_d;
      pf_grant_q <= pf_grant_d;
      pf_done_q  <= pf_done_d;
      pf_data_q  <= pf_data_d;
      dt_grant_q <= dt_grant_d;
      dt_done_q  <= dt_done_d;
      dt_data_q  <= dt_data_d;
      vaild_q    <= vaild_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dt_win)      state_d = DT_BUS;
        else if (pf_win) state_d = PF_BUS;
      end
      PF_BUS, DT_BUS: begin
        if (finish) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d   = starve_q;
    tcnt_d     = tcnt_q;
    pf_grant_d = 1'b0;
    pf_done_d  = 1'b0;
    pf_data_d  = pf_data_q;
    dt_grant_d = 1'b0;
    dt_done_d  = 1'b0;
    dt_data_d  = dt_data_q;
    vaild_d    = 1'b0;
    we_d       = we_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    timeout_d  = 1'b0;
    if (state_q == IDLE) begin
      if (!pf_req) starve_d = '0;
      if (dt_win) begin
        dt_grant_d = 1'b1;
        addr_d     = dt_address;
        we_d       = dt_write_enable;
        wd_d       = dt_write_data;
        tcnt_d     = '0;
        if (pf_req && (starve_q < SW'(DATA_STARVE_LIMIT))) starve_d = starve_q + SW'(1);
      end else if (pf_win) begin
        pf_grant_d = 1'b1;
        addr_d     = pf_address;
        we_d       = 1'b0;
        wd_d       = '0;
        tcnt_d     = '0;
        starve_d   = '0;
      end
    end else if (finish) begin
      timeout_d = !bus_ack;
      if (state_q == DT_BUS) begin
        dt_done_d = 1'b1;
        dt_data_d = bus_ack ? bus_data : 32'hFFFF_FFFF;
      end else begin
        pf_done_d = 1'b1;
        pf_data_d = bus_ack ? bus_data : 32'hFFFF_FFFF;
      end
    end else begin
      vaild_d = 1'b1;
      if ((TIMEOUT_CYCLES > 0) && vaild_q && !bus_ready) tcnt_d = tcnt_q + TW'(1);
    end
  end

  assign pf_grant         = pf_grant_q;
  assign pf_done          = pf_done_q;
  assign pf_data          = pf_data_q;
  assign dt_grant         = dt_grant_q;
  assign dt_done          = dt_done_q;
  assign dt_data          = dt_data_q;
  assign bus_vaild        = vaild_q;
  assign bus_write_enable = we_q;
  assign bus_address      = addr_q;
  assign bus_write_data   = wd_q;
  assign bus_timeout      = timeout_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_bus_access_arbiter.sv
// Directed bench for bus_access_arbiter: stimulus pushes expected grants/dones,
// independent monitors pop and compare whenever the DUT pulses a grant or done.
module tb_bus_access_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pf_req = 1'b0;
  logic [31:0] pf_address = '0;
  logic        pf_grant, pf_done;
  logic [31:0] pf_data;
  logic        dt_req = 1'b0;
  logic        dt_write_enable = 1'b0;
  logic [31:0] dt_address = '0;
  logic [31:0] dt_write_data = '0;
  logic        dt_grant, dt_done;
  logic [31:0] dt_data;
  logic        bus_vaild;
  logic        bus_ready = 1'b0;
  logic        bus_write_enable;
  logic [31:0] bus_address, bus_write_data;
  logic [31:0] bus_data = '0;
  logic        bus_timeout;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // done entry: {timeout, owner_is_dt, data}
  logic [33:0] exp_q[$];
  logic        exp_grant_q[$];

  bus_access_arbiter #(.DATA_STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .pf_req(pf_req), .pf_address(pf_address), .pf_grant(pf_grant),
    .pf_done(pf_done), .pf_data(pf_data),
    .dt_req(dt_req), .dt_write_enable(dt_write_enable), .dt_address(dt_address),
    .dt_write_data(dt_write_data), .dt_grant(dt_grant), .dt_done(dt_done),
    .dt_data(dt_data),
    .bus_vaild(bus_vaild), .bus_ready(bus_ready), .bus_write_enable(bus_write_enable),
    .bus_address(bus_address), .bus_write_data(bus_write_data), .bus_data(bus_data),
    .bus_timeout(bus_timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected event want none (cycle %0d)", name, cyc);
  endtask

  // scoreboard monitors
  always @(negedge clock) begin
    if (pf_grant || dt_grant) begin
      check("single_grant", 32'(pf_grant & dt_grant), 32'd0);
      if (exp_grant_q.size() == 0) flag("unexpected_grant");
      else check("grant_owner", 32'(dt_grant), 32'(exp_grant_q.pop_front()));
    end
  end

  always @(negedge clock) begin
    logic [33:0] e;
    if (pf_done || dt_done) begin
      check("single_done", 32'(pf_done & dt_done), 32'd0);
      if (exp_q.size() == 0) flag("unexpected_done");
      else begin
        e = exp_q.pop_front();
        check("done_timeout", 32'(bus_timeout), 32'(e[33]));
        check("done_owner", 32'(dt_done), 32'(e[32]));
        check("done_data", dt_done ? dt_data : pf_data, e[31:0]);
      end
    end else if (bus_timeout) begin
      flag("timeout_without_done");
    end
  end

  // driver tasks
  task automatic wait_grant();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (pf_grant || dt_grant) begin
        ok = 1;
        break;
      end
    end
    if (!ok) flag("grant_wait_expired");
  endtask

  task automatic issue(input logic is_dt, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd);
    @(posedge clock); #1;
    if (is_dt) begin
      dt_req = 1'b1; dt_write_enable = we; dt_address = addr; dt_write_data = wd;
    end else begin
      pf_req = 1'b1; pf_address = addr;
    end
    exp_grant_q.push_back(is_dt);
    wait_grant();
  endtask

  // called right after a grant was seen; bus_ready on the n-th bus_vaild cycle
  task automatic do_bus(input int n, input logic [31:0] data, input logic [31:0] addr,
                        input logic we, input logic [31:0] wd);
    for (int i = 1; i <= n; i++) begin
      @(posedge clock); #1;
      pf_req = 1'b0;
      dt_req = 1'b0;
      if (i == n) begin
        bus_ready = 1'b1;
        bus_data  = data;
      end
      @(negedge clock);
      check("bus_vaild", 32'(bus_vaild), 32'd1);
      check("bus_address", bus_address, addr);
      check("bus_write_enable", 32'(bus_write_enable), 32'(we));
      check("bus_write_data", bus_write_data, wd);
    end
    @(posedge clock); #1;
    bus_ready = 1'b0;
    bus_data  = '0;
    @(negedge clock);
    check("vaild_drop", 32'(bus_vaild), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vaild"}, 32'(bus_vaild), 32'd0);
    check({tag, "_grants"}, 32'({pf_grant, dt_grant}), 32'd0);
    check({tag, "_dones"}, 32'({pf_done, dt_done, bus_timeout}), 32'd0);
    check({tag, "_pf_data"}, pf_data, 32'd0);
    check({tag, "_dt_data"}, dt_data, 32'd0);
    check({tag, "_address"}, bus_address, 32'd0);
    check({tag, "_wr"}, 32'(bus_write_enable), 32'd0);
    check({tag, "_wdata"}, bus_write_data, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    int n;
    int last;
    logic order [10];

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_all_zero("reset");

    // PF read, ready on third bus cycle
    exp_q.push_back({1'b0, 1'b0, 32'h1234_5678});
    issue(1'b0, 1'b0, 32'h0000_FFF0, 32'd0);
    do_bus(3, 32'h1234_5678, 32'h0000_FFF0, 1'b0, 32'd0);
    @(negedge clock);
    check("pf_data_hold", pf_data, 32'h1234_5678);

    // DT write, dt_data samples bus_data too
    exp_q.push_back({1'b0, 1'b1, 32'h0BAD_F00D});
    issue(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    do_bus(2, 32'h0BAD_F00D, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF);

    // DT read with no bus_ready: 8 bus cycles then abort
    exp_q.push_back({1'b1, 1'b1, 32'hFFFF_FFFF});
    issue(1'b1, 1'b0, 32'h0000_0200, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      dt_req = 1'b0;
      @(negedge clock);
      check("tmo_vaild", 32'(bus_vaild), 32'd1);
    end
    @(posedge clock); #1;
    @(negedge clock);
    check("tmo_vaild_drop", 32'(bus_vaild), 32'd0);
    check("tmo_pulse", 32'(bus_timeout), 32'd1);
    check("tmo_pf_data_untouched", pf_data, 32'h1234_5678);

    // bus_ready on the terminal-count cycle completes normally
    exp_q.push_back({1'b0, 1'b1, 32'hCAFE_0008});
    issue(1'b1, 1'b0, 32'h0000_0300, 32'd0);
    do_bus(8, 32'hCAFE_0008, 32'h0000_0300, 1'b0, 32'd0);

    // both requesting, bus always ready: D,D,D,D,P repeating
    order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 10; i++) begin
      exp_grant_q.push_back(order[i]);
      exp_q.push_back({1'b0, order[i], 32'h0000_5A5A});
    end
    @(posedge clock); #1;
    pf_address = 32'h0000_1000; dt_address = 32'h0000_2000; dt_write_enable = 1'b0;
    bus_data = 32'h0000_5A5A; bus_ready = 1'b1;
    pf_req = 1'b1; dt_req = 1'b1;
    n = 0;
    for (int i = 0; i < 80 && n < 10; i++) begin
      @(negedge clock);
      if (pf_grant || dt_grant) begin
        check("prio_address", bus_address, pf_grant ? 32'h0000_1000 : 32'h0000_2000);
        n++;
      end
    end
    check("prio_grant_count", 32'(n), 32'd10);
    @(posedge clock); #1;
    pf_req = 1'b0; dt_req = 1'b0;
    repeat (3) @(posedge clock);
    #1 bus_ready = 1'b0; bus_data = '0;

    // DT stream without PF: one grant every 3 cycles
    for (int i = 0; i < 4; i++) begin
      exp_grant_q.push_back(1'b1);
      exp_q.push_back({1'b0, 1'b1, 32'h0000_0066});
    end
    @(posedge clock); #1;
    dt_address = 32'h0000_0400; bus_data = 32'h0000_0066; bus_ready = 1'b1; dt_req = 1'b1;
    n = 0;
    last = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clock);
      if (dt_grant) begin
        if (n > 0) check("stream_gap", 32'(cyc - last), 32'd3);
        last = cyc;
        n++;
      end
    end
    check("stream_grant_count", 32'(n), 32'd4);
    @(posedge clock); #1;
    dt_req = 1'b0;
    repeat (3) @(posedge clock);
    #1 bus_ready = 1'b0; bus_data = '0;

    // reset during an active bus cycle
    issue(1'b0, 1'b0, 32'h0000_4000, 32'd0);
    @(posedge clock); #1;
    pf_req = 1'b0;
    @(negedge clock);
    check("rst_pre_vaild", 32'(bus_vaild), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; bus_ready = 1'b1; bus_data = 32'h0000_0077;
    @(negedge clock);
    check_all_zero("midrst");
    repeat (3) begin
      @(posedge clock); #1;
      @(negedge clock);
      check("post_rst_vaild", 32'(bus_vaild), 32'd0);
    end
    bus_ready = 1'b0;

    repeat (5) @(posedge clock);
    @(negedge clock);
    check("done_queue_empty", 32'(exp_q.size()), 32'd0);
    check("grant_queue_empty", 32'(exp_grant_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
